// File: rtl/mrv1_issue_sched.sv
// Round-robin issue scheduler: one FU-ready, unparked thread issues per cycle.
// Define MRV1_ISSUE_SCHED_LSU_PARK_EN to park threads between LSU issue and LSU completion.
module mrv1_issue_sched #(
  parameter int unsigned NUM_THREADS_P = 8,
  parameter int unsigned NUM_FU_P      = 6,
  parameter int unsigned LSU_FU_IDX_P  = 1,
  localparam int unsigned tid_width_lp = $clog2(NUM_THREADS_P)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_THREADS_P-1:0]            thr_vld_i,
  input  logic [NUM_THREADS_P*NUM_FU_P-1:0]   thr_fu_sel_i,
  input  logic [NUM_FU_P-1:0]                 exec_fu_rdy_i,
  input  logic                                issue_stall_i,
  input  logic                                lsu_done_vld_i,
  input  logic [tid_width_lp-1:0]             lsu_done_tid_i,
  output logic                                issue_vld_o,
  output logic [tid_width_lp-1:0]             issue_tid_o,
  output logic [NUM_THREADS_P-1:0]            issue_gnt_o,
  output logic [NUM_FU_P-1:0]                 issue_fu_req_o,
  output logic [NUM_THREADS_P-1:0]            thr_parked_o
);

  logic [NUM_FU_P-1:0]       w_fu_sel [NUM_THREADS_P];
  logic [NUM_THREADS_P-1:0]  w_fu_hit;
  logic [NUM_THREADS_P-1:0]  w_parked;
  logic [NUM_THREADS_P-1:0]  w_elig;
  logic [tid_width_lp-1:0]   r_rr_ptr;
  logic [tid_width_lp-1:0]   w_idx;
  logic [tid_width_lp-1:0]   w_sel_tid;
  logic                      w_sel_vld;
  logic                      w_sel_lsu;

  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS_P; t++) begin
      w_fu_sel[t] = thr_fu_sel_i[t*NUM_FU_P +: NUM_FU_P];
      w_fu_hit[t] = |(w_fu_sel[t] & exec_fu_rdy_i);
    end
  end

  // Reset is folded in here so all grant outputs read zero while rst_i is high.
  assign w_elig = thr_vld_i & ~w_parked & w_fu_hit
                & {NUM_THREADS_P{~issue_stall_i & ~rst_i}};

  // Search upward from rr_ptr; the tid-width add wraps naturally.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_tid = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < NUM_THREADS_P; i++) begin
      w_idx = r_rr_ptr + tid_width_lp'(i);
      if (!w_sel_vld && w_elig[w_idx]) begin
        w_sel_vld = 1'b1;
        w_sel_tid = w_idx;
      end
    end
  end

  always_comb begin
    issue_gnt_o    = '0;
    issue_fu_req_o = '0;
    w_sel_lsu      = 1'b0;
    if (w_sel_vld) begin
      issue_gnt_o[w_sel_tid] = 1'b1;
      issue_fu_req_o         = w_fu_sel[w_sel_tid];
      w_sel_lsu              = w_fu_sel[w_sel_tid][LSU_FU_IDX_P];
    end
  end

  assign issue_vld_o = w_sel_vld;
  assign issue_tid_o = w_sel_tid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_sel_vld) begin
      r_rr_ptr <= w_sel_tid + tid_width_lp'(1);
    end
  end

`ifdef MRV1_ISSUE_SCHED_LSU_PARK_EN
  typedef enum logic {
    PARK_RUN    = 1'b0,
    PARK_PARKED = 1'b1
  } park_e;

  park_e r_park_state [NUM_THREADS_P];
  park_e w_park_next  [NUM_THREADS_P];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned t = 0; t < NUM_THREADS_P; t++) begin
        r_park_state[t] <= PARK_RUN;
      end
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS_P; t++) begin
        r_park_state[t] <= w_park_next[t];
      end
    end
  end

  // A done aimed at a thread still in RUN (including the one being granted) is ignored.
  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS_P; t++) begin
      w_park_next[t] = r_park_state[t];
      unique case (r_park_state[t])
        PARK_RUN: begin
          if (issue_gnt_o[t] && w_sel_lsu) begin
            w_park_next[t] = PARK_PARKED;
          end
        end
        PARK_PARKED: begin
          if (lsu_done_vld_i && (lsu_done_tid_i == tid_width_lp'(t))) begin
            w_park_next[t] = PARK_RUN;
          end
        end
        default: w_park_next[t] = PARK_RUN;
      endcase
    end
  end

  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS_P; t++) begin
      w_parked[t] = (r_park_state[t] == PARK_PARKED);
    end
  end

  assign thr_parked_o = w_parked;
`else
  logic w_unused_lsu;

  assign w_parked     = '0;
  assign thr_parked_o = '0;
  assign w_unused_lsu = ^{lsu_done_vld_i, lsu_done_tid_i, w_sel_lsu};
`endif

endmodule

// File: tb/tb_mrv1_issue_sched.sv
// Directed bench for mrv1_issue_sched: fairness, FU back-pressure, wrap/stall, LSU park, async reset.
// Expectations follow MRV1_ISSUE_SCHED_LSU_PARK_EN as seen by this compilation unit.
module tb_mrv1_issue_sched;

`ifdef MRV1_ISSUE_SCHED_LSU_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  localparam logic [5:0] ALU = 6'b000001;
  localparam logic [5:0] LSU = 6'b000010;
  localparam logic [5:0] FU3 = 6'b001000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  thr_vld_i;
  logic [47:0] thr_fu_sel_i;
  logic [5:0]  exec_fu_rdy_i;
  logic        issue_stall_i;
  logic        lsu_done_vld_i;
  logic [2:0]  lsu_done_tid_i;
  logic        issue_vld_o;
  logic [2:0]  issue_tid_o;
  logic [7:0]  issue_gnt_o;
  logic [5:0]  issue_fu_req_o;
  logic [7:0]  thr_parked_o;

  logic [5:0]  sel [8];
  int          total = 0;
  int          bad   = 0;

  int unsigned lsu_tid  [10];
  logic [7:0]  lsu_park [10];
  int unsigned rp_tid_d;
  logic [5:0]  rp_fu_d;

  mrv1_issue_sched #(
    .NUM_THREADS_P (8),
    .NUM_FU_P      (6),
    .LSU_FU_IDX_P  (1)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .thr_vld_i      (thr_vld_i),
    .thr_fu_sel_i   (thr_fu_sel_i),
    .exec_fu_rdy_i  (exec_fu_rdy_i),
    .issue_stall_i  (issue_stall_i),
    .lsu_done_vld_i (lsu_done_vld_i),
    .lsu_done_tid_i (lsu_done_tid_i),
    .issue_vld_o    (issue_vld_o),
    .issue_tid_o    (issue_tid_o),
    .issue_gnt_o    (issue_gnt_o),
    .issue_fu_req_o (issue_fu_req_o),
    .thr_parked_o   (thr_parked_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    thr_fu_sel_i = '0;
    for (int t = 0; t < 8; t++) thr_fu_sel_i[t*6 +: 6] = sel[t];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cyc(input string tag, input logic ev, input int unsigned et,
                     input logic [5:0] efu, input logic [7:0] epark);
    logic [7:0] egnt;
    egnt = ev ? (8'b1 << et) : 8'h00;
    #1;
    for (int t = 0; t < 8; t++) begin
      if (thr_vld_i[t]) begin
        assert ($onehot0(sel[t])) else begin
          bad++;
          $error("FAIL %s.fu_sel_onehot t=%0d: observed=%b expected=onehot", tag, t, sel[t]);
        end
      end
    end
    chk($sformatf("%s.vld", tag),    32'(issue_vld_o),    32'(ev));
    chk($sformatf("%s.tid", tag),    32'(issue_tid_o),    ev ? et : 32'd0);
    chk($sformatf("%s.gnt", tag),    32'(issue_gnt_o),    32'(egnt));
    chk($sformatf("%s.fu", tag),     32'(issue_fu_req_o), ev ? 32'(efu) : 32'd0);
    chk($sformatf("%s.parked", tag), 32'(thr_parked_o),   PARK ? 32'(epark) : 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i          = 1'b1;
    thr_vld_i      = 8'hFF;
    exec_fu_rdy_i  = 6'h3F;
    issue_stall_i  = 1'b0;
    lsu_done_vld_i = 1'b0;
    lsu_done_tid_i = 3'd0;
    for (int t = 0; t < 8; t++) sel[t] = ALU;

    // Outputs forced low during reset even with every thread eligible.
    @(negedge clk_i);
    cyc("reset", 1'b0, 0, 6'h00, 8'h00);
    rst_i = 1'b0;

    for (int c = 0; c < 16; c++) cyc($sformatf("fair%0d", c), 1'b1, c % 8, ALU, 8'h00);

    thr_vld_i     = 8'h24;
    sel[2]        = FU3;
    sel[5]        = ALU;
    exec_fu_rdy_i = 6'b000001;
    for (int c = 0; c < 4; c++) cyc($sformatf("bp_blk%0d", c), 1'b1, 5, ALU, 8'h00);
    exec_fu_rdy_i = 6'b001001;
    cyc("bp_alt0", 1'b1, 2, FU3, 8'h00);
    cyc("bp_alt1", 1'b1, 5, ALU, 8'h00);
    cyc("bp_alt2", 1'b1, 2, FU3, 8'h00);
    cyc("bp_alt3", 1'b1, 5, ALU, 8'h00);

    exec_fu_rdy_i = 6'h3F;
    thr_vld_i     = 8'h40;
    cyc("wrap_pre", 1'b1, 6, ALU, 8'h00);
    thr_vld_i = 8'h81;
    cyc("wrap7", 1'b1, 7, ALU, 8'h00);
    cyc("wrap0", 1'b1, 0, ALU, 8'h00);
    issue_stall_i = 1'b1;
    for (int c = 0; c < 3; c++) cyc($sformatf("stall%0d", c), 1'b0, 0, 6'h00, 8'h00);
    issue_stall_i = 1'b0;
    thr_vld_i     = 8'hFF;
    cyc("post_stall", 1'b1, 1, ALU, 8'h00);

    // LSU sequence: thread 3 to LSU, thread 0 to ALU; done for 3 in cycle 5 and (stalled) cycle 8.
    lsu_tid  = PARK ? '{3, 0, 0, 0, 0, 0, 3, 0, 0, 3} : '{3, 0, 3, 0, 3, 0, 3, 0, 0, 3};
    lsu_park = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h00};
    thr_vld_i = 8'h09;
    sel[3]    = LSU;
    sel[0]    = ALU;
    for (int c = 0; c < 10; c++) begin
      lsu_done_vld_i = (c == 5) || (c == 8);
      lsu_done_tid_i = 3'd3;
      issue_stall_i  = (c == 8);
      cyc($sformatf("lsu%0d", c), c != 8, lsu_tid[c], lsu_tid[c] == 3 ? LSU : ALU, lsu_park[c]);
    end
    lsu_done_vld_i = 1'b0;
    issue_stall_i  = 1'b0;

    thr_vld_i = 8'h52;
    sel[1]    = LSU;
    sel[4]    = LSU;
    sel[6]    = ALU;
    cyc("rp_a", 1'b1, 4, LSU, 8'h08);
    cyc("rp_b", 1'b1, 6, ALU, 8'h18);
    cyc("rp_c", 1'b1, 1, LSU, 8'h18);
    rp_tid_d = PARK ? 6 : 4;
    rp_fu_d  = PARK ? ALU : LSU;
    cyc("rp_d", 1'b1, rp_tid_d, rp_fu_d, 8'h1A);
    #3;
    rst_i = 1'b1;
    cyc("rp_rst", 1'b0, 0, 6'h00, 8'h00);
    rst_i = 1'b0;
    cyc("rp_first", 1'b1, 1, LSU, 8'h00);
    cyc("rp_next", 1'b1, 4, LSU, 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
